// File: rtl/sys_pkg.sv
// ---------------------------------------------------------------------------
// sys_pkg: shared system types and defaults for reset/clock consumers.
// Holds the reset-controller state and reset-source encodings plus the
// default sequencing parameters used by sys_rst_ctrl.
// ---------------------------------------------------------------------------
package sys_pkg;

  // Default number of synchroniser flops on reset deassertion.
  localparam int unsigned SYS_RST_SYNC_STAGES = 32'd2;
  // Default minimum assertion width after the synchronised release.
  localparam int unsigned SYS_RST_STRETCH_CYC = 32'd16;
  // Default spacing between consecutive output releases.
  localparam int unsigned SYS_RST_STEP_CYC    = 32'd4;
  // Default number of sequenced reset outputs.
  localparam int unsigned SYS_RST_NUM_OUT     = 32'd3;

  // Reset controller sequencing states.
  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } t_rst_state;

  // Source of the most recent reset event.
  typedef enum logic {
    RST_SRC_PIN  = 1'b0,
    RST_SRC_SOFT = 1'b1
  } t_rst_src;

  // Larger of two unsigned values; used to size shared counters.
  function automatic int unsigned sys_max_u(input int unsigned a, input int unsigned b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage : sys_pkg

// File: rtl/sys_rst_sync.sv
// ---------------------------------------------------------------------------
// sys_rst_sync: STAGES-deep reset synchroniser.
// Asserts asynchronously with i_rst_n, releases synchronously to i_clk after
// STAGES edges. Usable standalone in any clock domain.
// o_rst_n_next exposes the stage feeding the output flop, so a consumer can
// act on the very edge at which o_rst_n_sync becomes 1.
// ---------------------------------------------------------------------------
module sys_rst_sync #(
  parameter int unsigned STAGES = 32'd2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_rst_n_sync,
  output logic o_rst_n_next
);

  // A single flop cannot filter metastability on the release edge.
  if (STAGES < 32'd2) begin : g_chk_stages
    $error("sys_rst_sync: STAGES must be >= 2");
  end

  logic [STAGES-1:0] r_sync;
  logic [STAGES:0]   w_sync_shift;

  // Shift a constant 1 towards the output; the chain reads all-ones once released.
  assign w_sync_shift = {r_sync, 1'b1};

  // Synchroniser chain: async clear, one 1 shifted in per clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= w_sync_shift[STAGES-1:0];
    end
  end

  assign o_rst_n_sync = r_sync[STAGES-1];
  assign o_rst_n_next = r_sync[STAGES-2];

endmodule : sys_rst_sync

// File: rtl/sys_rst_ctrl.sv
// ---------------------------------------------------------------------------
// sys_rst_ctrl: system reset sequencer.
// Takes the async active-low board reset and a synchronous soft-reset level
// and produces NUM_OUT ordered active-low resets: async assert, synchronous
// deassert, minimum-width stretch, then staggered release (bit 0 first).
// rst_done flags the fully released system; rst_src records the last cause.
// All outputs are flops cleared by rst, so they never glitch.
// ---------------------------------------------------------------------------
module sys_rst_ctrl
  import sys_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYS_RST_SYNC_STAGES,
  parameter int unsigned STRETCH_CYC = SYS_RST_STRETCH_CYC,
  parameter int unsigned STEP_CYC    = SYS_RST_STEP_CYC,
  parameter int unsigned NUM_OUT     = SYS_RST_NUM_OUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               soft_rst_req,
  output logic [NUM_OUT-1:0] rst_n_out,
  output logic               rst_done,
  output logic               rst_src
);

  // ---- parameter range checks ---------------------------------------------
  if (SYNC_STAGES < 32'd2) begin : g_chk_sync
    $error("sys_rst_ctrl: SYNC_STAGES must be >= 2");
  end
  if (STRETCH_CYC < 32'd1) begin : g_chk_stretch
    $error("sys_rst_ctrl: STRETCH_CYC must be >= 1");
  end
  if (STEP_CYC < 32'd1) begin : g_chk_step
    $error("sys_rst_ctrl: STEP_CYC must be >= 1");
  end
  if (NUM_OUT < 32'd1) begin : g_chk_num
    $error("sys_rst_ctrl: NUM_OUT must be >= 1");
  end

  // ---- counter sizing and compare constants -------------------------------
  // One counter serves both the stretch and the step phases.
  localparam int unsigned CNT_MAX = sys_max_u(STRETCH_CYC, STEP_CYC);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 32'd1);

  localparam logic [CNT_W-1:0]   L_CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]   L_CNT_ONE  = CNT_W'(1);
  // Stretch ends on the edge that sees the count already at STRETCH_CYC:
  // the count is 1 after the first stretch edge, so that is STRETCH_CYC edges.
  localparam logic [CNT_W-1:0]   L_STRETCH  = CNT_W'(STRETCH_CYC);
  // The step count restarts at 0 on each release, so STEP_CYC-1 marks the
  // STEP_CYC-th edge after the previous release.
  localparam logic [CNT_W-1:0]   L_STEP_M1  = CNT_W'(STEP_CYC - 32'd1);
  localparam logic [NUM_OUT-1:0] L_OUT_NONE = '0;
  localparam logic [NUM_OUT-1:0] L_OUT_BIT0 = NUM_OUT'(1);

  // ---- state -------------------------------------------------------------
  t_rst_state         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_OUT-1:0] r_rst_n;
  logic               r_done;
  t_rst_src           r_src;

  t_rst_state         w_state_nx;
  logic [CNT_W-1:0]   w_cnt_nx;
  logic [NUM_OUT-1:0] w_rst_n_nx;
  logic               w_done_nx;
  t_rst_src           w_src_nx;

  logic               w_sync_out;
  logic               w_sync_next;
  logic [NUM_OUT:0]   w_rst_n_ext;
  logic [NUM_OUT-1:0] w_rst_n_shift;
  logic               w_soft_hit;

  // ---- deassertion synchroniser ------------------------------------------
  sys_rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_rst_sync (
    .i_clk        (clk),
    .i_rst_n      (rst),
    .o_rst_n_sync (w_sync_out),
    .o_rst_n_next (w_sync_next)
  );

  // Thermometer step: releasing the next output shifts a 1 in from bit 0,
  // which keeps released outputs released (monotonic).
  assign w_rst_n_ext   = {r_rst_n, 1'b1};
  assign w_rst_n_shift = w_rst_n_ext[NUM_OUT-1:0];

  // The pin reset dominates: a soft request only acts once the sequence runs.
  assign w_soft_hit = soft_rst_req && (r_state != ASSERT);

  // Next-state, counter and output sequencing.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_rst_n_nx = r_rst_n;
    w_done_nx  = r_done;
    w_src_nx   = r_src;

    case (r_state)
      ASSERT: begin
        w_rst_n_nx = L_OUT_NONE;
        w_done_nx  = 1'b0;
        // Leave on the edge at which the synchroniser output turns to 1.
        if (w_sync_next || w_sync_out) begin
          w_state_nx = STRETCH;
          w_cnt_nx   = L_CNT_ONE;
        end else begin
          w_cnt_nx   = L_CNT_ZERO;
        end
      end

      STRETCH: begin
        if (r_cnt == L_STRETCH) begin
          w_rst_n_nx = L_OUT_BIT0;
          w_cnt_nx   = L_CNT_ZERO;
          if (NUM_OUT == 32'd1) begin
            w_state_nx = RUN;
          end else begin
            w_state_nx = RELEASE;
          end
        end else begin
          w_cnt_nx = r_cnt + L_CNT_ONE;
        end
      end

      RELEASE: begin
        if (r_cnt == L_STEP_M1) begin
          w_rst_n_nx = w_rst_n_shift;
          w_cnt_nx   = L_CNT_ZERO;
          if (w_rst_n_shift[NUM_OUT-1]) begin
            w_state_nx = RUN;
          end else begin
            w_state_nx = RELEASE;
          end
        end else begin
          w_cnt_nx = r_cnt + L_CNT_ONE;
        end
      end

      RUN: begin
        // Entered on the edge releasing the last output; done follows one edge later.
        w_done_nx = 1'b1;
      end

      default: begin
        w_state_nx = ASSERT;
        w_cnt_nx   = L_CNT_ZERO;
        w_rst_n_nx = L_OUT_NONE;
        w_done_nx  = 1'b0;
      end
    endcase

    // Soft reset re-asserts everything and parks the count at 0 for as long
    // as the request is held, so the stretch is measured from its release.
    if (w_soft_hit) begin
      w_state_nx = STRETCH;
      w_cnt_nx   = L_CNT_ZERO;
      w_rst_n_nx = L_OUT_NONE;
      w_done_nx  = 1'b0;
      w_src_nx   = RST_SRC_SOFT;
    end else begin
      w_src_nx   = w_src_nx;
    end
  end

  // Sequencer registers: async clear from the board reset pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ASSERT;
      r_cnt   <= L_CNT_ZERO;
      r_rst_n <= L_OUT_NONE;
      r_done  <= 1'b0;
      r_src   <= RST_SRC_PIN;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_rst_n <= w_rst_n_nx;
      r_done  <= w_done_nx;
      r_src   <= w_src_nx;
    end
  end

  assign rst_n_out = r_rst_n;
  assign rst_done  = r_done;
  assign rst_src   = r_src;

endmodule : sys_rst_ctrl

// File: doc/sys_rst_ctrl.md
Name: sys_rst_ctrl

Overview:
- System reset controller that sits directly upstream of every block consuming the sys_pkg reset/clock types.
- Takes the raw asynchronous active-low board reset and a synchronous soft-reset request.
- Produces NUM_OUT ordered, glitch-free, active-low reset outputs: asynchronous assert, synchronous deassert, minimum-width stretch, staggered release.
- Also flags when the whole system is out of reset, and which source caused the last reset.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on reset deassertion (>=2)
STRETCH_CYC, 16, clk cycles all outputs stay asserted after the synchronised reset releases (>=1)
STEP_CYC, 4, clk cycles between releases of consecutive outputs (>=1; unused when NUM_OUT=1)
NUM_OUT, 3, number of sequenced reset outputs (>=1)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  reset, asynchronous, active-low
soft_rst_req  in  1  synchronous level request; 1 = hold/force system reset
rst_n_out  out  NUM_OUT  sequenced active-low resets; bit 0 released first
rst_done  out  1  1 = all outputs released
rst_src  out  1  cause of last reset: 0 = rst pin, 1 = soft_rst_req

Behaviour:
- rst low (async, no clock needed):
  - rst_n_out = 0, rst_done = 0, rst_src = 0.
  - Synchroniser chain cleared, state = ASSERT, counter = 0.
- Every output is a flop with async clear from rst, so there are no combinational glitches.
- Synchroniser: shifts 1 in per edge once rst is high.
  - Define edge S as the first posedge at which the last stage is 1.
  - If rst deasserts between edges, S = SYNC_STAGES edges later.
- FSM states: ASSERT, STRETCH, RELEASE, RUN.
  - ASSERT: all outputs 0. Moves to STRETCH at edge S with counter = 1.
  - STRETCH: counter increments each edge. At the edge where counter reaches STRETCH_CYC, rst_n_out[0] is set to 1, the counter clears and the FSM moves to RELEASE, or directly to RUN if NUM_OUT = 1.
  - RELEASE: releases rst_n_out[i] (i = 1..NUM_OUT-1) STEP_CYC edges after rst_n_out[i-1]. After the last release the FSM moves to RUN.
  - RUN: rst_done rises one edge after rst_n_out[NUM_OUT-1] rises. Steady state.
- Resulting timing: rst_n_out[i] rises at edge S+STRETCH_CYC+i*STEP_CYC; rst_done rises one edge after the last output.
- Released outputs stay released (monotonic) until the next reset event.
- soft_rst_req = 1, sampled at any edge in STRETCH, RELEASE or RUN:
  - Next edge: all rst_n_out = 0, rst_done = 0, rst_src = 1.
  - FSM goes to STRETCH with counter = 0.
  - While the request stays 1, the counter holds at 0.
  - The first edge with the request at 0 starts the count, so outputs stay low for at least STRETCH_CYC edges after the request drops.
- soft_rst_req in ASSERT: ignored (the pin reset dominates); rst_src stays 0.
- rst asserted mid-sequence or in RUN: immediate async return to the reset values above; overrides any soft request.
- Counter width: $clog2(max(STRETCH_CYC, STEP_CYC)+1). Saturation never occurs.
- Elaboration fails ($error) if any parameter is outside its stated range.

Decomposition:
- sys_pkg gains:
  - t_rst_state enum {ASSERT, STRETCH, RELEASE, RUN}
  - t_rst_src enum {RST_SRC_PIN, RST_SRC_SOFT}
  - package defaults for SYNC_STAGES, STRETCH_CYC, STEP_CYC
- One sub-module: sys_rst_sync, a parameterised SYNC_STAGES-deep async-assert/sync-deassert synchroniser. It is reusable standalone for other clock domains.
- FSM, counter and output sequencing stay in sys_rst_ctrl.

Test Plan (defaults; edges counted from the first posedge after rst rises mid-cycle = edge 1):
- Power-on: rst low 5 cycles, then high -> all outputs 0 while rst low; S = edge 2; rst_n_out[0] at edge 18, [1] at 22, [2] at 26; rst_done at edge 27; rst_src = 0.
- Async assert: rst pulled low between edges while in RUN -> rst_n_out = 0, rst_done = 0 within the same cycle with no clock edge; full sequence repeats on release.
- Soft reset: in RUN, soft_rst_req = 1 for 3 cycles then 0 -> outputs 0 and rst_src = 1 at the edge after the first sample; rst_n_out[0] rises 16 edges after the first edge sampling the request at 0; [1] and [2] follow at +4 and +8.
- Soft reset mid-RELEASE: request raised one edge after rst_n_out[0] rises -> [0] returns to 0, [1] never rises; restart from STRETCH.
- Sub-edge rst glitch: rst low for half a cycle in STRETCH -> immediate full reset; counter restarts from the synchroniser and S is recomputed.
- Corners with NUM_OUT=1, STRETCH_CYC=1, SYNC_STAGES=3: S = edge 3; rst_n_out[0] at edge 4; rst_done at edge 5; RELEASE state never entered.
